vidac_scan: RTL and testbench

//   Raster scan-out for the 320x200x8bpp framebuffer that vidac draws into (shared video RAM, 0x00000..0x0F9FF).

---
 rtl/vidac_scan.sv | 124 ++++++++++++
 tb/tb_vidac_scan.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vidac_scan.sv
// Raster scan-out: 640x400@70Hz VGA timing, 2x2 pixel doubling of a 320x200x8bpp framebuffer,
// byte fetch from shared video RAM and 256x12 palette lookup to 4:4:4 RGB plus syncs.
module vidac_scan #(
    parameter int          H_VIS  = 640,
    parameter int          H_FP   = 16,
    parameter int          H_SYNC = 96,
    parameter int          H_BP   = 48,
    parameter int          V_VIS  = 400,
    parameter int          V_FP   = 12,
    parameter int          V_SYNC = 2,
    parameter int          V_BP   = 35,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b1,
    parameter logic [16:0] BASE   = 17'h00000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [16:0] a,
    input  logic [7:0]  i,
    output logic        fetch,
    input  logic        pal_we,
    input  logic [7:0]  pal_idx,
    input  logic [11:0] pal_data,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        vbl
);

    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] H_SS     = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SE     = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] V_SS     = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SE     = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [9:0]  x, y;
    logic [8:0]  xx, yy;
    logic        vis, hs_raw, vs_raw, vbl_raw;
    logic [16:0] addr_next;

    logic        vis_d2;
    logic [7:0]  idx_d2;
    logic        hs_d1, hs_d2, vs_d1, vs_d2, vbl_d1, vbl_d2;

    logic [11:0] pal [256];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (x == H_LAST) begin
            x <= '0;
            y <= (y == V_LAST) ? 10'd0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    assign xx = x[9:1];
    assign yy = y[9:1];

    // Address is yy*320 + xx built from two shifts.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        vis       = (x < H_VIS_L) && (y < V_VIS_L);
        hs_raw    = ((x >= H_SS) && (x < H_SE)) ? HS_POL : ~HS_POL;
        vs_raw    = ((y >= V_SS) && (y < V_SE)) ? VS_POL : ~VS_POL;
        vbl_raw   = (x == 10'd0) && (y == V_VIS_L);
        addr_next = BASE + {yy, 8'h00} + {2'b00, yy, 6'h00} + {8'h00, xx};
    end

    // NOTE: the palette RAM has no reset; contents are undefined until software writes them.
    always_ff @(posedge clock) begin
        if (pal_we) pal[pal_idx] <= pal_data;
    end

    // Three-stage pipe: address, RAM data -> palette index, palette -> pins; syncs ride alongside.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a      <= BASE;
            fetch  <= 1'b0;
            vis_d2 <= 1'b0;
            idx_d2 <= '0;
            hs_d1  <= ~HS_POL;
            hs_d2  <= ~HS_POL;
            hs     <= ~HS_POL;
            vs_d1  <= ~VS_POL;
            vs_d2  <= ~VS_POL;
            vs     <= ~VS_POL;
            vbl_d1 <= 1'b0;
            vbl_d2 <= 1'b0;
            vbl    <= 1'b0;
            r      <= '0;
            g      <= '0;
            b      <= '0;
        end else begin
            a      <= addr_next;
            fetch  <= vis;
            hs_d1  <= hs_raw;
            vs_d1  <= vs_raw;
            vbl_d1 <= vbl_raw;

            vis_d2 <= fetch;
            idx_d2 <= i;
            hs_d2  <= hs_d1;
            vs_d2  <= vs_d1;
            vbl_d2 <= vbl_d1;

            hs     <= hs_d2;
            vs     <= vs_d2;
            vbl    <= vbl_d2;
            // A palette write on this same edge is not seen until the next read.
            if (vis_d2) {r, g, b} <= pal[idx_d2];
            else        {r, g, b} <= 12'h000;
        end
    end

endmodule

// File: tb/tb_vidac_scan.sv
// Bench for vidac_scan: a raster model pushes expected pin values into a queue on every edge and
// pops them three edges later; scenario tasks add directed checks on reset, palette and timing.
module tb_vidac_scan;

    localparam int V_VIS  = 20;
    localparam int V_FP   = 3;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 5;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_TOT  = 800;
    localparam logic [16:0] LAST_ADDR = 17'(((V_VIS - 1) / 2) * 320 + 319);

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [16:0] a;
    logic [7:0]  i;
    logic        fetch;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_idx = '0;
    logic [11:0] pal_data = '0;
    logic [3:0]  r, g, b;
    logic        hs, vs, vbl;

    vidac_scan #(
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SYNC(V_SYNC),
        .V_BP  (V_BP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .i       (i),
        .fetch   (fetch),
        .pal_we  (pal_we),
        .pal_idx (pal_idx),
        .pal_data(pal_data),
        .r       (r),
        .g       (g),
        .b       (b),
        .hs      (hs),
        .vs      (vs),
        .vbl     (vbl)
    );

    always #20 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    always @(posedge clock) cyc++;

    // Video RAM holds byte = addr[7:0]; read data follows the registered address.
    logic [7:0] mem [0:131071];
    initial for (int k = 0; k < 131072; k++) mem[k] = 8'(k);
    assign i = mem[a];

    function automatic logic [11:0] pal_init(input int k);
        logic [7:0] kk;
        kk = 8'(k);
        return {kk[7:4], kk[3:0], ~kk[3:0]};
    endfunction

    typedef struct {
        logic        vis;
        logic [16:0] addr;
        logic [7:0]  idx;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vbl;
    } exp_t;

    exp_t q[$];
    int tx, ty, sx, sy;
    logic [11:0] pal_model [256];

    always @(posedge clock) if (pal_we) pal_model[pal_idx] <= pal_data;

    always @(posedge clock or negedge reset_n) begin : model
        exp_t e, h;
        if (!reset_n) begin
            q.delete();
            tx = 0; ty = 0; sx = -1; sy = -1;
        end else begin
            if (q.size() >= 2) begin
                h = q[0];
                h.rgb = h.vis ? pal_model[h.idx] : 12'h000;
                q[0] = h;
            end
            e.vis  = (tx < 640) && (ty < V_VIS);
            e.addr = 17'((ty / 2) * 320 + tx / 2);
            e.idx  = mem[e.addr];
            e.rgb  = 12'h000;
            e.hs   = !((tx >= 656) && (tx < 752));
            e.vs   = (ty >= V_VIS + V_FP) && (ty < V_VIS + V_FP + V_SYNC);
            e.vbl  = (tx == 0) && (ty == V_VIS);
            q.push_back(e);
            sx = tx; sy = ty;
            tx++;
            if (tx == H_TOT) begin
                tx = 0;
                ty++;
                if (ty == V_TOT) ty = 0;
            end
        end
    end

    always @(negedge clock) begin : scoreboard
        exp_t lst, h;
        if (reset_n && q.size() > 0) begin
            lst = q[q.size() - 1];
            total_cnt++;
            if (fetch !== lst.vis)
                $display("FAIL fetch at x=%0d y=%0d: got %b want %b", sx, sy, fetch, lst.vis);
            else pass_cnt++;
            if (lst.vis) begin
                total_cnt++;
                if (a !== lst.addr)
                    $display("FAIL addr at x=%0d y=%0d: got %0d want %0d", sx, sy, a, lst.addr);
                else pass_cnt++;
            end
            if (q.size() == 3) begin
                h = q.pop_front();
                total_cnt++;
                if ({r, g, b, hs, vs, vbl} !== {h.rgb, h.hs, h.vs, h.vbl})
                    $display("FAIL pins cyc=%0d: got rgb=%h hs=%b vs=%b vbl=%b want rgb=%h hs=%b vs=%b vbl=%b",
                             cyc, {r, g, b}, hs, vs, vbl, h.rgb, h.hs, h.vs, h.vbl);
                else pass_cnt++;
            end
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 256; k++) begin
            @(negedge clock);
            pal_we = 1'b1; pal_idx = 8'(k); pal_data = pal_init(k);
        end
        @(negedge clock);
        pal_we = 1'b0;
        total_cnt++;
        if ({a, fetch, r, g, b, hs, vs, vbl} !== {17'h0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_vals: got a=%h fetch=%b rgb=%h hs=%b vs=%b vbl=%b",
                     a, fetch, {r, g, b}, hs, vs, vbl);
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clock);
        total_cnt++;
        if ({a, fetch} !== {17'h0, 1'b1})
            $display("FAIL first_fetch: got a=%0d fetch=%b want a=0 fetch=1", a, fetch);
        else pass_cnt++;
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({r, g, b, hs, vs} !== {12'h00F, 1'b1, 1'b0})
            $display("FAIL first_pixel: got rgb=%h hs=%b vs=%b want rgb=00f hs=1 vs=0", {r, g, b}, hs, vs);
        else pass_cnt++;
    endtask

    task automatic test_palette_write();
        int n;
        for (n = 0; n < 2000 && !(tx == 12 && ty < V_VIS); n++) @(negedge clock);
        total_cnt++;
        if (!(tx == 12 && ty < V_VIS)) begin
            $display("FAIL pal_wait: position x=12 not reached");
            return;
        end
        pass_cnt++;
        pal_we = 1'b1; pal_idx = 8'd5; pal_data = 12'hF0A;
        @(negedge clock);
        pal_we = 1'b0;
        total_cnt++;
        if ({r, g, b} !== 12'h05A) $display("FAIL pal_old: got %h want 05a", {r, g, b});
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if ({r, g, b} !== 12'hF0A) $display("FAIL pal_new: got %h want f0a", {r, g, b});
        else pass_cnt++;
    endtask

    task automatic test_hsync();
        int n, t0, len;
        for (n = 0; n < 1000 && hs !== 1'b0; n++) @(negedge clock);
        t0 = cyc;
        for (len = 0; len < 200 && hs === 1'b0; len++) @(negedge clock);
        total_cnt++;
        if (len != 96) $display("FAIL hs_width: got %0d clocks want 96", len);
        else pass_cnt++;
        for (n = 0; n < 1000 && hs !== 1'b0; n++) @(negedge clock);
        total_cnt++;
        if (cyc - t0 != H_TOT) $display("FAIL line_period: got %0d want %0d", cyc - t0, H_TOT);
        else pass_cnt++;
    endtask

    task automatic test_last_pixel();
        int n;
        for (n = 0; n < 30000 && !(sx == 639 && sy == V_VIS - 1); n++) @(negedge clock);
        total_cnt++;
        if ({a, fetch} !== {LAST_ADDR, 1'b1})
            $display("FAIL last_addr: got a=%0d fetch=%b want a=%0d fetch=1", a, fetch, LAST_ADDR);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (fetch !== 1'b0) $display("FAIL hblank_fetch: got %b want 0", fetch);
        else pass_cnt++;
    endtask

    task automatic test_vblank();
        int n, t0, pulses;
        for (n = 0; n < 30000 && vbl !== 1'b1; n++) @(negedge clock);
        t0 = cyc;
        pulses = 0;
        @(negedge clock);
        total_cnt++;
        if (vbl !== 1'b0) $display("FAIL vbl_width: got %b want 0 one clock after pulse", vbl);
        else pass_cnt++;
        for (n = 0; n < 30000 && vbl !== 1'b1; n++) @(negedge clock);
        total_cnt++;
        if (cyc - t0 != V_TOT * H_TOT)
            $display("FAIL frame_period: got %0d want %0d", cyc - t0, V_TOT * H_TOT);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        for (n = 0; n < 30000 && !(sx == 300 && sy == 10); n++) @(negedge clock);
        #5 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({a, fetch, r, g, b, hs, vs, vbl} !== {17'h0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0})
            $display("FAIL async_reset: got a=%h fetch=%b rgb=%h hs=%b vs=%b vbl=%b",
                     a, fetch, {r, g, b}, hs, vs, vbl);
        else pass_cnt++;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total_cnt++;
        if ({a, fetch} !== {17'h0, 1'b1})
            $display("FAIL restart: got a=%0d fetch=%b want a=0 fetch=1", a, fetch);
        else pass_cnt++;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_palette_write();
        test_hsync();
        test_last_pixel();
        test_vblank();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
